psram_cmd_seq: RTL and testbench

PSRAM_CMD_SEQ -- requirements
Module: psram_cmd_seq

---
 rtl/psram_pkg.sv | 39 +++
 rtl/psram_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_psram_cmd_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// psram_pkg : opcodes, state encoding and byte-select helper for psram_cmd_seq
// Revision  : 1.0
// ============================================================================
package psram_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CS_SETUP  = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BYTE = 3'd3,
        CS_HOLD   = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Frame layout: opcode, address MSB..LSB, then payload (write) or dummy (read).
    function automatic logic [7:0] cmd_byte(input logic        we,
                                            input logic [23:0] addr,
                                            input logic [7:0]  wdata,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = we ? OP_WRITE : OP_READ;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            3'd4:    b = we ? wdata : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psram_cmd_seq.sv
`default_nettype none
// ============================================================================
// psram_cmd_seq : single-byte PSRAM read/write sequencer driving an SPI byte engine
// Revision      : 1.0
// ============================================================================
module psram_cmd_seq
    import psram_pkg::*;
#(
    parameter int unsigned CS_SETUP_CYC = 2,
    parameter int unsigned CS_HOLD_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_data_in,
    input  logic [7:0]  spi_data_out,
    input  logic        spi_busy,
    input  logic        spi_new_data
);

    // Terminal counts; only meaningful when the matching parameter is non-zero.
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cs_n_q, cs_n_d;
    logic        spi_start_q, spi_start_d;
    logic [7:0]  spi_data_in_q, spi_data_in_d;
    logic [7:0]  rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= 24'h0;
            wdata_q       <= 8'h00;
            idx_q         <= 3'd0;
            cnt_q         <= 8'd0;
            cs_n_q        <= 1'b1;
            spi_start_q   <= 1'b0;
            spi_data_in_q <= 8'h00;
            rdata_q       <= 8'h00;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            cs_n_q        <= cs_n_d;
            spi_start_q   <= spi_start_d;
            spi_data_in_q <= spi_data_in_d;
            rdata_q       <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        cs_n_d        = cs_n_q;
        spi_start_d   = 1'b0;
        spi_data_in_d = spi_data_in_q;
        rdata_d       = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    cs_n_d  = 1'b0;
                    state_d = (CS_SETUP_CYC == 0) ? ISSUE : CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ISSUE: begin
                if (!spi_busy) begin
                    spi_start_d   = 1'b1;
                    spi_data_in_d = cmd_byte(we_q, addr_q, wdata_q, idx_q);
                    state_d       = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (spi_new_data) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = 3'd0;
                        // Only the byte clocked back during the dummy slot is read data.
                        if (!we_q) begin
                            rdata_d = spi_data_out;
                        end
                        if (CS_HOLD_CYC == 0) begin
                            cs_n_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d   = 8'd0;
                            state_d = CS_HOLD;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    cs_n_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign rdata       = rdata_q;
    assign cs_n        = cs_n_q;
    assign spi_start   = spi_start_q;
    assign spi_data_in = spi_data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_cmd_seq.sv
`default_nettype none
// ============================================================================
// tb_psram_cmd_seq : self-checking bench for psram_cmd_seq with SPI engine models
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_psram_cmd_seq;

    localparam int BT  = 3;
    localparam int LAT = 1 + 2 + 5 * (BT + 1) + 2 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (default timing)
    logic        req, we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        ready, done, cs_n, spi_start;
    logic [7:0]  rdata, spi_data_in;
    logic [7:0]  spi_data_out = 8'h00;
    logic        spi_busy, spi_new_data;
    logic        nd_model = 1'b0, nd_inj, eng_busy = 1'b0, stall;
    int          rem = 0, k = 0;
    logic [7:0]  resp;

    assign spi_busy     = eng_busy | stall;
    assign spi_new_data = nd_model | nd_inj;

    psram_cmd_seq #(.CS_SETUP_CYC(2), .CS_HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .cs_n(cs_n),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_new_data(spi_new_data)
    );

    // Timing instance (no setup, hold of 3)
    logic        req_b, we_b;
    logic [23:0] addr_b;
    logic [7:0]  wdata_b;
    logic        ready_b, done_b, cs_n_b, spi_start_b;
    logic [7:0]  rdata_b, spi_data_in_b;
    logic [7:0]  spi_data_out_b = 8'h00;
    logic        spi_new_data_b = 1'b0, eng_b = 1'b0;
    int          rem_b = 0, k_b = 0, nd_b = 0;

    psram_cmd_seq #(.CS_SETUP_CYC(0), .CS_HOLD_CYC(3)) dut_t (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ready(ready_b), .done(done_b), .rdata(rdata_b), .cs_n(cs_n_b),
        .spi_start(spi_start_b), .spi_data_in(spi_data_in_b),
        .spi_data_out(spi_data_out_b), .spi_busy(eng_b), .spi_new_data(spi_new_data_b)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int start_cnt = 0, done_cnt = 0, done_cyc = 0, req_cyc = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_rdata[$];
    logic [7:0] cur_rdata = 8'h00;
    logic busy_at_edge = 1'b0, start_prev = 1'b0, done_prev = 1'b0;

    int fall_e = -1, rise_e = -1, start_e = -1, nd5_e = -1, done_cnt_b = 0;
    logic csb_prev = 1'b1;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  resp;
        logic [7:0]  exp_rdata;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= spi_busy;
    end

    // SPI byte engine model: byte lasts BT cycles from the start pulse to new_data.
    always @(negedge clk) begin
        nd_model = 1'b0;
        if (rst) begin
            eng_busy = 1'b0; rem = 0; k = 0;
        end else begin
            if (cs_n) k = 0;
            if (eng_busy) begin
                rem--;
                if (rem == 0) begin
                    eng_busy     = 1'b0;
                    nd_model     = 1'b1;
                    spi_data_out = (k == 5) ? resp : (8'hE0 | 8'(k));
                end
            end
            if (spi_start) begin
                eng_busy = 1'b1; rem = BT - 1; k++;
            end
        end
    end

    always @(negedge clk) begin
        spi_new_data_b = 1'b0;
        if (rst) begin
            eng_b = 1'b0; rem_b = 0; k_b = 0; nd_b = 0;
        end else begin
            if (cs_n_b) k_b = 0;
            if (eng_b) begin
                rem_b--;
                if (rem_b == 0) begin
                    eng_b          = 1'b0;
                    spi_new_data_b = 1'b1;
                    spi_data_out_b = (k_b == 5) ? 8'h66 : 8'hD0;
                    nd_b++;
                    if (nd_b == 5) nd5_e = cyc + 1;
                end
            end
            if (spi_start_b) begin
                eng_b = 1'b1; rem_b = 1; k_b++;
            end
        end
    end

    // Scoreboard / protocol monitor for the main instance
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_start) begin
                start_cnt++;
                check("start_while_busy", 32'(busy_at_edge), 32'd0);
                check("start_one_cycle", 32'(start_prev), 32'd0);
                check("cs_n_low_at_start", 32'(cs_n), 32'd0);
                check("byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
                if (exp_bytes.size() > 0)
                    check("spi_data_in", 32'(spi_data_in), 32'(exp_bytes.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_one_cycle", 32'(done_prev), 32'd0);
                check("cs_n_high_at_done", 32'(cs_n), 32'd1);
                check("ready_low_at_done", 32'(ready), 32'd0);
                check("done_expected", 32'(exp_rdata.size() > 0), 32'd1);
                if (exp_rdata.size() > 0)
                    check("rdata", 32'(rdata), 32'(exp_rdata.pop_front()));
            end
        end
        start_prev = spi_start;
        done_prev  = done;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (csb_prev && !cs_n_b) fall_e = cyc;
            if (!csb_prev && cs_n_b) rise_e = cyc;
            if (spi_start_b && start_e < 0) start_e = cyc;
            if (done_b) done_cnt_b++;
        end
        csb_prev = cs_n_b;
    end

    task automatic push_cmd(input logic w, input logic [23:0] a, input logic [7:0] d,
                            input logic [7:0] er);
        exp_bytes.push_back(w ? 8'h02 : 8'h03);
        exp_bytes.push_back(a[23:16]);
        exp_bytes.push_back(a[15:8]);
        exp_bytes.push_back(a[7:0]);
        exp_bytes.push_back(w ? d : 8'h00);
        exp_rdata.push_back(er);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [7:0] d,
                         input logic [7:0] r, input logic [7:0] er);
        wait_ready();
        we = w; addr = a; wdata = d; resp = r; req = 1'b1;
        push_cmd(w, a, d, er);
        req_cyc = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        int t = 0;
        while (done_cnt < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(done_cnt), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bs, t;
        vecs[0] = '{1'b1, 24'h123456, 8'hA5, 8'h77, 8'h00};
        vecs[1] = '{1'b0, 24'h000010, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 24'hFFFFFF, 8'h00, 8'h11, 8'h3C};
        vecs[3] = '{1'b0, 24'hABCDEF, 8'h00, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 24'h000000, 8'h00, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 24'h000000, 8'hFF, 8'h00, 8'hFF};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 24'h0; wdata = 8'h00;
        stall = 1'b0; nd_inj = 1'b0; resp = 8'h00;
        req_b = 1'b0; we_b = 1'b0; addr_b = 24'h000020; wdata_b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_spi_data_in", 32'(spi_data_in), 32'd0);
        check("rst_cs_n_b", 32'(cs_n_b), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);

        foreach (vecs[i]) begin
            base = done_cnt;
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].resp, vecs[i].exp_rdata);
            wait_done(base + 1, "vec_done");
            check("vec_latency", 32'(done_cyc - req_cyc + 1), 32'(LAT));
            cur_rdata = vecs[i].exp_rdata;
        end

        // Back-to-back: req held high through DONE
        wait_ready();
        base = done_cnt; bs = start_cnt;
        we = 1'b1; addr = 24'h00ABCD; wdata = 8'h5A; resp = 8'h00; req = 1'b1;
        push_cmd(1'b1, 24'h00ABCD, 8'h5A, cur_rdata);
        push_cmd(1'b1, 24'h00ABCD, 8'h5A, cur_rdata);
        wait_done(base + 1, "b2b_first_done");
        repeat (3) @(negedge clk);
        req = 1'b0;
        wait_done(base + 2, "b2b_second_done");
        repeat (40) @(negedge clk);
        check("b2b_done_pulses", 32'(done_cnt - base), 32'd2);
        check("b2b_starts", 32'(start_cnt - bs), 32'd10);

        // Busy stall in ISSUE, with stray new_data pulses outside WAIT_BYTE
        base = done_cnt; bs = start_cnt;
        stall = 1'b1;
        issue(1'b0, 24'h55AA00, 8'h00, 8'h99, 8'h99);
        for (int i = 0; i < 12; i++) begin
            nd_inj = (i == 0 || i == 5);
            @(negedge clk);
        end
        nd_inj = 1'b0;
        check("stall_no_start", 32'(start_cnt - bs), 32'd0);
        stall = 1'b0;
        wait_done(base + 1, "stall_done");
        check("stall_starts", 32'(start_cnt - bs), 32'd5);
        cur_rdata = 8'h99;

        // Reset in the middle of byte 2
        bs = start_cnt;
        issue(1'b0, 24'h000777, 8'h00, 8'h42, 8'h42);
        t = 0;
        while (start_cnt < bs + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("midrst_reach_byte2", 32'(start_cnt - bs), 32'd3);
        rst = 1'b1;
        #1;
        check("midrst_cs_n_immediate", 32'(cs_n), 32'd1);
        check("midrst_done_low", 32'(done), 32'd0);
        exp_bytes.delete();
        exp_rdata.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - base), 32'd0);
        check("midrst_rdata_cleared", 32'(rdata), 32'd0);
        issue(1'b0, 24'h000010, 8'h00, 8'h5A, 8'h5A);
        wait_done(base + 1, "midrst_new_read_done");
        check("midrst_rdata_final", 32'(rdata), 32'h5A);

        // Timing instance: zero setup, hold of three
        @(negedge clk);
        we_b = 1'b0; req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        t = 0;
        while (done_cnt_b < 1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check("tim_done_b", 32'(done_cnt_b), 32'd1);
        check("tim_setup0_start", 32'(start_e - fall_e), 32'd1);
        check("tim_hold3_rise", 32'(rise_e - nd5_e), 32'd3);
        check("tim_rdata_b", 32'(rdata_b), 32'h66);
        check("tim_cs_n_idle_b", 32'(cs_n_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
